// File: rtl/md_scheduler.sv
// md_scheduler
//   Sequencer for the E-stage multiply/divide unit and owner of the HI/LO
//   registers. One mult/div/mthi/mtlo command is accepted per start pulse.
//   Mult/div latency is modelled with a down-counter. The result is computed
//   at issue, held in pending registers, and committed to HI/LO on the last
//   busy cycle.
//
// Optional feature macro: MD_DIV0_FAST_EN
//   When it is defined, a DIV/DIVU whose divisor is zero finishes after a
//   single busy cycle.
//   When it is undefined, a divide by zero takes the full DIV_CYCLES.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous active-low reset (0 = reset)
//   start     in   1   E-stage command valid, one-cycle pulse
//   md_op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, else no-op
//   A         in   32  forwarded rs operand
//   B         in   32  forwarded rt operand
//   md_use    in   1   D-stage instruction is md-class
//   busy      out  1   operation in flight
//   md_stall  out  1   stall request: md_use & (start | busy)
//   done      out  1   pulse in the cycle HI/LO take a mult/div result
//   HI        out  32  HI register
//   LO        out  32  LO register
//
// FSM states
//   state | meaning
//   IDLE  | ready; mthi/mtlo write directly, mult/div load pending + counter
//   RUN   | operation in flight, counting down to commit at cnt==0
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use,
  output logic        busy,
  output logic        md_stall,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_N1 = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_N1  = 4'(DIV_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_wr;

  // Multiply: explicit sign extension keeps the 64-bit product exact.
  logic signed [63:0] w_a_sx;
  logic signed [63:0] w_b_sx;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;

  assign w_a_sx   = {{32{A[31]}}, A};
  assign w_b_sx   = {{32{B[31]}}, B};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide goes through magnitudes. This gives truncation toward zero
  // and a remainder that takes the dividend's sign. 0x80000000 / -1 also
  // falls out as quotient 0x80000000 and remainder 0.
  // The divisor is forced to 1 when B is zero so the operator never sees
  // zero. Those results are discarded anyway.
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_dsr_s;
  logic [31:0] w_dsr_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_divs_q;
  logic [31:0] w_divs_r;
  logic [31:0] w_divu_q;
  logic [31:0] w_divu_r;
  logic        w_b_zero;

  assign w_b_zero = (B == 32'd0);
  assign w_abs_a  = A[31] ? (~A + 32'd1) : A;
  assign w_abs_b  = B[31] ? (~B + 32'd1) : B;
  assign w_dsr_s  = w_b_zero ? 32'd1 : w_abs_b;
  assign w_dsr_u  = w_b_zero ? 32'd1 : B;
  assign w_q_mag  = w_abs_a / w_dsr_s;
  assign w_r_mag  = w_abs_a % w_dsr_s;
  assign w_divs_q = (A[31] ^ B[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_divs_r = A[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  assign w_divu_q = A / w_dsr_u;
  assign w_divu_r = A % w_dsr_u;

  // Counter preload for a divide; a zero divisor may take the short path.
  logic [3:0] w_div_n1;
`ifdef MD_DIV0_FAST_EN
  assign w_div_n1 = w_b_zero ? 4'd0 : DIV_N1;
`else
  assign w_div_n1 = DIV_N1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1: begin
                r_pend_hi <= (md_op == 3'd0) ? w_prod_s[63:32] : w_prod_u[63:32];
                r_pend_lo <= (md_op == 3'd0) ? w_prod_s[31:0]  : w_prod_u[31:0];
                r_pend_wr <= 1'b1;
                r_cnt     <= MULT_N1;
                r_done    <= (MULT_N1 == 4'd0);
                r_busy    <= 1'b1;
                r_state   <= RUN;
              end
              3'd2, 3'd3: begin
                r_pend_hi <= (md_op == 3'd2) ? w_divs_r : w_divu_r;
                r_pend_lo <= (md_op == 3'd2) ? w_divs_q : w_divu_q;
                r_pend_wr <= !w_b_zero;
                r_cnt     <= w_div_n1;
                r_done    <= (w_div_n1 == 4'd0);
                r_busy    <= 1'b1;
                r_state   <= RUN;
              end
              3'd4: r_hi <= A;
              3'd5: r_lo <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // A start arriving here is a protocol violation and is ignored.
          if (r_cnt == 4'd0) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt  <= r_cnt - 4'd1;
            r_done <= (r_cnt == 4'd1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign HI       = r_hi;
  assign LO       = r_lo;
  assign md_stall = md_use & (start | r_busy);

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler
//   Directed self-checking bench for md_scheduler.
//   Each scenario task drives its stimulus and compares outputs against
//   hand-computed values.
//   Inputs change 1 ns after a rising edge. Outputs are sampled after that
//   settling delay, well away from the edges.
module tb_md_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use;
  logic        busy;
  logic        md_stall;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks;
  int n_fail;

`ifdef MD_DIV0_FAST_EN
  localparam int DIV0_CYCLES = 1;
`else
  localparam int DIV0_CYCLES = 10;
`endif

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .md_use   (md_use),
    .busy     (busy),
    .md_stall (md_stall),
    .done     (done),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div and follow it until busy drops (bounded at 40 cycles).
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc;
    int dpos;
    int dcnt;
    start = 1'b1; md_op = op; A = a; B = b;
    tick();
    start = 1'b0;
    cyc = 0; dpos = -1; dcnt = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (done === 1'b1) begin dcnt++; dpos = cyc; end
      tick();
    end
    n_checks++;
    if (cyc !== exp_n) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, exp_n);
    end
    n_checks++;
    if (dcnt !== 1 || dpos !== exp_n) begin
      n_fail++;
      $display("FAIL %s done_pulse: got count %0d at cycle %0d expected 1 at cycle %0d",
               name, dcnt, dpos, exp_n);
    end
    n_checks++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      n_fail++;
      $display("FAIL %s hilo: got HI=%h LO=%h expected HI=%h LO=%h",
               name, HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0; md_use = 1'b0;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || md_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b HI=%h LO=%h stall=%b expected 0 0 0 0 0",
               busy, done, HI, LO, md_stall);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    run_op("mult_3x-2", 3'd0, 32'd3, 32'hFFFFFFFE, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
  endtask

  task automatic test_div();
    run_op("div_-7/2", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_7/2", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_7/-2", 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
  endtask

  task automatic test_stall();
    md_use = 1'b1;
    #1;
    n_checks++;
    if (md_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle: got %b expected 0", md_stall);
    end
    start = 1'b1; md_op = 3'd0; A = 32'd2; B = 32'd3;
    #1;
    n_checks++;
    if (md_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_start: got %b expected 1", md_stall);
    end
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (md_stall !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_busy%0d: got stall=%b busy=%b expected 1 1", i, md_stall, busy);
      end
      tick();
    end
    n_checks++;
    if (md_stall !== 1'b0 || busy !== 1'b0 || LO !== 32'd6 || HI !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_release: got stall=%b busy=%b HI=%h LO=%h expected 0 0 0 6",
               md_stall, busy, HI, LO);
    end
    md_use = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; md_op = 3'd4; A = 32'h1234;
    tick();
    n_checks++;
    if (HI !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi: got HI=%h busy=%b done=%b expected 1234 0 0", HI, busy, done);
    end
    md_op = 3'd5; A = 32'h5678;
    tick();
    start = 1'b0;
    n_checks++;
    if (HI !== 32'h1234 || LO !== 32'h5678 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mtlo: got HI=%h LO=%h busy=%b done=%b expected 1234 5678 0 0",
               HI, LO, busy, done);
    end
    start = 1'b1; md_op = 3'd6; A = 32'hDEAD;
    tick();
    start = 1'b0;
    n_checks++;
    if (HI !== 32'h1234 || LO !== 32'h5678 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unknown_op: got HI=%h LO=%h busy=%b expected 1234 5678 0", HI, LO, busy);
    end
  endtask

  // A start during RUN must be ignored; here an MTHI is attempted mid-mult.
  task automatic test_start_in_run();
    int cyc;
    start = 1'b1; md_op = 3'd0; A = 32'd4; B = 32'd5;
    tick();
    md_op = 3'd4; A = 32'hBEEF;
    tick();
    start = 1'b0;
    cyc = 1;
    while (busy === 1'b1 && cyc < 40) begin cyc++; tick(); end
    n_checks++;
    if (cyc !== 5 || HI !== 32'd0 || LO !== 32'd20) begin
      n_fail++;
      $display("FAIL start_in_run: got cycles=%0d HI=%h LO=%h expected 5 0 14", cyc, HI, LO);
    end
  endtask

  task automatic test_div0();
    start = 1'b1; md_op = 3'd4; A = 32'hAA;
    tick();
    md_op = 3'd5;
    tick();
    start = 1'b0;
    run_op("div0", 3'd2, 32'd9, 32'd0, DIV0_CYCLES, 32'hAA, 32'hAA);
    run_op("divu0", 3'd3, 32'd9, 32'd0, DIV0_CYCLES, 32'hAA, 32'hAA);
  endtask

  task automatic test_reset_mid_op();
    int dcnt;
    start = 1'b1; md_op = 3'd0; A = 32'd3; B = 32'hFFFFFFFE;
    tick();
    start = 1'b0;
    tick();
    tick();
    // now in the 3rd busy cycle
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got busy=%b HI=%h LO=%h done=%b expected 0 0 0 0",
               busy, HI, LO, done);
    end
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) dcnt++;
      tick();
    end
    n_checks++;
    if (dcnt !== 0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_discard: got activity=%0d HI=%h LO=%h expected 0 0 0", dcnt, HI, LO);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_back_to_back();
    test_start_in_run();
    test_div0();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
